sram_controller: RTL and testbench

- Multi-cycle controller between the MEM stage and the external 16-bit asynchronous SRAM.
- Accepts the 32-bit load/store requests produced by the decoded mem_read/mem_write controls.
- Splits each request into two 16-bit half-word accesses with programmable wait states.
- Deasserts ready while busy; the pipeline uses ready to freeze every stage until the access completes.

---
 rtl/sram_controller_pkg.sv | 29 ++
 rtl/sram_controller_if.sv | 16 +
 rtl/sram_controller.sv | 108 ++++++++++
 tb/tb_sram_controller.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/sram_controller_pkg.sv
// Shared types and constants for the MEM-stage SRAM controller.
// State encodings, SRAM bus widths and the captured-request layout live here.
package sram_controller_pkg;

    localparam int unsigned SRAM_ADDR_W = 18;
    localparam int unsigned SRAM_DATA_W = 16;
    localparam int unsigned WORD_W      = 32;
    localparam logic [WORD_W-1:0] DEFAULT_BASE_ADDR = 32'd1024;

    typedef enum logic [1:0] {
        SRAM_IDLE = 2'd0,
        SRAM_LO   = 2'd1,
        SRAM_HI   = 2'd2,
        SRAM_DONE = 2'd3
    } sram_state_e;

    // Only the SRAM-visible word index of the offset is kept.
    typedef struct packed {
        logic                    is_write;
        logic [SRAM_ADDR_W-2:0]  word;
        logic [WORD_W-1:0]       wdata;
    } sram_req_t;

    function automatic logic [SRAM_ADDR_W-1:0] half_addr(input logic [SRAM_ADDR_W-2:0] word,
                                                         input logic hi);
        return {word, hi};
    endfunction

endpackage

// File: rtl/sram_controller_if.sv
// Pipeline-side load/store bus between the MEM stage and the SRAM controller.
interface sram_controller_if;
    import sram_controller_pkg::*;

    logic              wr_en;
    logic              rd_en;
    logic [WORD_W-1:0] address;
    logic [WORD_W-1:0] write_data;
    logic [WORD_W-1:0] read_data;
    logic              ready;

    modport master (output wr_en, rd_en, address, write_data,
                    input  read_data, ready);
    modport slave  (input  wr_en, rd_en, address, write_data,
                    output read_data, ready);
endinterface

// File: rtl/sram_controller.sv
// Splits 32-bit loads/stores into two 16-bit SRAM phases with programmable wait states.
// ready stays low while an access is in flight so the pipeline freezes around it.
module sram_controller
    import sram_controller_pkg::*;
#(
    parameter logic [WORD_W-1:0] BASE_ADDR   = DEFAULT_BASE_ADDR,
    parameter int unsigned       WAIT_CYCLES = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    sram_controller_if.slave       bus,
    inout  wire  [SRAM_DATA_W-1:0] SRAM_DQ,
    output logic [SRAM_ADDR_W-1:0] SRAM_ADDR,
    output logic                   SRAM_UB_N,
    output logic                   SRAM_LB_N,
    output logic                   SRAM_WE_N,
    output logic                   SRAM_CE_N,
    output logic                   SRAM_OE_N
);

    localparam logic [3:0] LAST_CNT = 4'(WAIT_CYCLES - 1);

    sram_state_e             state_q, state_d;
    logic [3:0]              wait_cnt;
    sram_req_t               req_q;
    logic                    last;
    logic                    req_present;
    logic [WORD_W-1:0]       offset;
    logic                    dq_oe;
    logic [SRAM_DATA_W-1:0]  dq_out;
    logic                    unused_offset_bits;

    assign req_present        = bus.wr_en | bus.rd_en;
    assign last               = (wait_cnt == LAST_CNT);
    assign offset             = bus.address - BASE_ADDR;
    assign unused_offset_bits = ^{offset[WORD_W-1:SRAM_ADDR_W+1], offset[1:0]};
    assign SRAM_DQ            = dq_oe ? dq_out : {SRAM_DATA_W{1'bz}};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= SRAM_IDLE;
            wait_cnt <= '0;
            req_q    <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == SRAM_LO || state_q == SRAM_HI)
                wait_cnt <= last ? 4'd0 : wait_cnt + 4'd1;
            else
                wait_cnt <= '0;
            if (state_q == SRAM_IDLE && req_present) begin
                req_q.is_write <= bus.wr_en;
                req_q.word     <= offset[SRAM_ADDR_W:2];
                req_q.wdata    <= bus.write_data;
            end
        end
    end

    // Each half is sampled on the last edge of its phase, after the bus has settled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.read_data <= '0;
        end else if (!req_q.is_write && last) begin
            if (state_q == SRAM_LO)
                bus.read_data[SRAM_DATA_W-1:0] <= SRAM_DQ;
            else if (state_q == SRAM_HI)
                bus.read_data[WORD_W-1:SRAM_DATA_W] <= SRAM_DQ;
        end
    end

    always_comb begin
        state_d   = state_q;
        bus.ready = 1'b0;
        SRAM_ADDR = '0;
        SRAM_UB_N = 1'b1;
        SRAM_LB_N = 1'b1;
        SRAM_WE_N = 1'b1;
        SRAM_CE_N = 1'b1;
        SRAM_OE_N = 1'b1;
        dq_oe     = 1'b0;
        dq_out    = '0;
        case (state_q)
            SRAM_IDLE: begin
                bus.ready = ~req_present;
                if (req_present)
                    state_d = SRAM_LO;
            end
            SRAM_LO, SRAM_HI: begin
                SRAM_CE_N = 1'b0;
                SRAM_UB_N = 1'b0;
                SRAM_LB_N = 1'b0;
                SRAM_WE_N = ~req_q.is_write;
                SRAM_OE_N = req_q.is_write;
                SRAM_ADDR = half_addr(req_q.word, state_q == SRAM_HI);
                dq_oe     = req_q.is_write;
                dq_out    = (state_q == SRAM_HI) ? req_q.wdata[WORD_W-1:SRAM_DATA_W]
                                                 : req_q.wdata[SRAM_DATA_W-1:0];
                if (last)
                    state_d = (state_q == SRAM_LO) ? SRAM_HI : SRAM_DONE;
            end
            SRAM_DONE: begin
                bus.ready = 1'b1;
                state_d   = SRAM_IDLE;
            end
            default: state_d = SRAM_IDLE;
        endcase
    end

endmodule

// File: tb/tb_sram_controller.sv
// Randomized scoreboard bench for sram_controller against a behavioural 256K x 16 SRAM.
module tb_sram_controller;
    import sram_controller_pkg::*;

    localparam int          W    = 2;
    localparam logic [31:0] BASE = 32'd1024;

    typedef struct {
        logic [17:0] addr;
        logic        wr;
        logic [15:0] data;
    } bus_exp_t;

    typedef struct {
        logic        rd;
        logic [31:0] data;
    } done_exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    sram_controller_if bus();
    wire  [15:0] sram_dq;
    logic [17:0] sram_addr;
    logic        ub_n, lb_n, we_n, ce_n, oe_n;

    sram_controller #(.BASE_ADDR(BASE), .WAIT_CYCLES(W)) dut (
        .clk(clk), .rst(rst), .bus(bus), .SRAM_DQ(sram_dq), .SRAM_ADDR(sram_addr),
        .SRAM_UB_N(ub_n), .SRAM_LB_N(lb_n), .SRAM_WE_N(we_n), .SRAM_CE_N(ce_n), .SRAM_OE_N(oe_n)
    );

    // Behavioural asynchronous SRAM
    bit [15:0] sram_mem [0:262143];
    assign sram_dq = (!ce_n && !oe_n && we_n) ? sram_mem[sram_addr] : 16'bz;
    always @(negedge clk) if (!ce_n && !we_n) sram_mem[sram_addr] <= sram_dq;

    int          vectors = 0;
    int          miscompares = 0;
    logic        mon_en = 1'b0;
    bus_exp_t    bus_q[$];
    done_exp_t   done_q[$];
    logic [15:0] ref_mem [logic [17:0]];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] ref_rd(input logic [17:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : 16'h0;
    endfunction

    // Issue one request, record what the bus and the completion should look like,
    // then hold the request while scrambling the fields the controller must ignore.
    task automatic issue(input logic w, input logic r, input logic [31:0] a, input logic [31:0] d);
        logic [31:0] off;
        logic [17:0] h0;
        int          n;
        @(posedge clk); #1;
        bus.wr_en = w; bus.rd_en = r; bus.address = a; bus.write_data = d;
        off = a - BASE;
        h0  = 18'(((off / 4) % 131072) * 2);
        if (w) begin
            ref_mem[h0]      = d[15:0];
            ref_mem[h0 + 1]  = d[31:16];
        end
        for (int c = 0; c < W; c++) bus_q.push_back('{addr: h0, wr: w, data: d[15:0]});
        for (int c = 0; c < W; c++) bus_q.push_back('{addr: h0 + 18'd1, wr: w, data: d[31:16]});
        done_q.push_back('{rd: !w, data: {ref_rd(h0 + 18'd1), ref_rd(h0)}});
        n = 0;
        forever begin
            @(negedge clk); n++;
            if (bus.ready || n > 4 * W + 8) break;
            @(posedge clk); #1;
            bus.address = $urandom; bus.write_data = $urandom;
        end
        check("done_seen", {31'd0, bus.ready}, 32'd1);
    endtask

    task automatic idle(input int n);
        @(posedge clk); #1;
        bus.wr_en = 1'b0; bus.rd_en = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check("ready_idle", {31'd0, bus.ready}, 32'd1);
        end
    endtask

    // SRAM bus monitor
    always @(negedge clk) begin
        if (!rst && mon_en) begin
            if (!ce_n) begin
                if (bus_q.size() == 0) begin
                    check("unexpected_access", {14'd0, sram_addr}, 32'hFFFFFFFF);
                end else begin
                    bus_exp_t e;
                    e = bus_q.pop_front();
                    check("sram_addr", {14'd0, sram_addr}, {14'd0, e.addr});
                    check("strobes", {28'd0, we_n, oe_n, ub_n, lb_n}, e.wr ? 32'h4 : 32'h8);
                    if (e.wr) check("dq_write", {16'd0, sram_dq}, {16'd0, e.data});
                end
            end else begin
                check("strobes_idle", {28'd0, we_n, oe_n, ub_n, lb_n}, 32'hF);
            end
        end
    end

    // Completion monitor
    int          busy = 0;
    logic [31:0] last_rd = '0;
    always @(negedge clk) begin
        if (rst || !mon_en) begin
            busy = 0;
        end else if (!bus.ready) begin
            busy++;
        end else if (busy > 0) begin
            if (done_q.size() == 0) begin
                check("unexpected_done", bus.read_data, 32'hFFFFFFFF);
            end else begin
                done_exp_t e;
                e = done_q.pop_front();
                check("latency", busy, 2 * W + 1);
                if (e.rd) last_rd = e.data;
                check(e.rd ? "read_data" : "read_hold", bus.read_data, last_rd);
            end
            busy = 0;
        end
    end

    initial begin
        rst = 1'b1;
        bus.wr_en = 1'b0; bus.rd_en = 1'b0; bus.address = '0; bus.write_data = '0;
        repeat (2) @(posedge clk); #1;
        check("rst_strobes", {27'd0, ce_n, we_n, oe_n, ub_n, lb_n}, 32'h1F);
        check("rst_addr", {14'd0, sram_addr}, 32'd0);
        check("rst_read_data", bus.read_data, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("rst_ready", {31'd0, bus.ready}, 32'd1);
        mon_en = 1'b1;

        issue(1'b1, 1'b0, 32'd1024, 32'hDEADBEEF);
        issue(1'b0, 1'b1, 32'd1024, $urandom);
        idle(2);
        issue(1'b1, 1'b0, 32'd1032, 32'h12345678);
        issue(1'b0, 1'b1, 32'd1032, $urandom);
        issue(1'b1, 1'b1, 32'd1040, 32'hCAFEF00D);
        issue(1'b0, 1'b1, 32'd1040, $urandom);

        for (int i = 0; i < 60; i++) begin
            logic        w, r;
            logic [31:0] a;
            w = 1'($urandom_range(0, 1));
            r = w ? 1'($urandom_range(0, 1)) : 1'b1;
            if ($urandom_range(0, 3) == 0)
                a = $urandom & 32'hFFFFFFFC;
            else
                a = BASE + 4 * $urandom_range(0, 15) + ($urandom_range(0, 3) << 19);
            issue(w, r, a, $urandom);
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
        end

        issue(1'b1, 1'b0, BASE + 32'd400, 32'hA5A55A5A);
        issue(1'b0, 1'b1, BASE + 32'd400, $urandom);
        idle(2);
        check("bus_q_drained", bus_q.size(), 0);
        check("done_q_drained", done_q.size(), 0);

        // Reset in the middle of the low phase of a write
        @(posedge clk); #1;
        mon_en = 1'b0;
        bus.wr_en = 1'b1; bus.address = BASE; bus.write_data = 32'h0BADF00D;
        @(posedge clk); #1;
        bus.wr_en = 1'b0;
        @(negedge clk);
        check("mid_lo_active", {30'd0, ce_n, we_n}, 32'd0);
        #2 rst = 1'b1;
        #1;
        check("midrst_strobes", {27'd0, ce_n, we_n, oe_n, ub_n, lb_n}, 32'h1F);
        check("midrst_read_data", bus.read_data, 32'd0);
        check("midrst_addr", {14'd0, sram_addr}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_ready", {31'd0, bus.ready}, 32'd1);
        check("post_rst_strobes", {27'd0, ce_n, we_n, oe_n, ub_n, lb_n}, 32'h1F);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
